// File: rtl/md_hilo_ctrl.sv
// HI/LO owner and mul/div sequencer for EXE; 32-step restoring divider.
// Optional DIV_ZERO_FAST_EN: divide by zero completes in one cycle.
module md_hilo_ctrl #(
  parameter int MULT_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        req_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi_rdata,
  output logic [31:0] lo_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_RESP
  } state_e;

  localparam logic [4:0] MUL_CNT0 =
    (MULT_LAT > 1) ? 5'(MULT_LAT - 2) : 5'd0;
  localparam bit MUL_DIRECT = (MULT_LAT <= 1);

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  op_q;
  logic [31:0] src1_q, src2_q;
  logic [31:0] rem_q, quo_q, den_q;
  logic [31:0] hi_q, lo_q;
  logic        qneg_q, rneg_q;
  logic        resp_valid_q, busy_q;

  logic        accept, is_div, s_div;
  logic [31:0] abs1, abs2;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [63:0] sprod, uprod;
  logic        m_wr_hi, m_wr_lo;
  logic [31:0] m_hi, m_lo;
  logic [32:0] shifted, diff;
  logic [31:0] step_rem, step_quo;
  logic [31:0] fix_rem, fix_quo;
`ifdef DIV_ZERO_FAST_EN
  logic        fast_zero;
  logic [31:0] zero_lo;
`endif

  assign req_ready  = !busy_q && !flush;
  assign resp_valid = resp_valid_q;
  assign busy       = busy_q;
  assign hi_rdata   = hi_q;
  assign lo_rdata   = lo_q;

  always_comb begin
    accept = req_valid && req_ready;
    is_div = (req_op == 3'd2) || (req_op == 3'd3);
    s_div  = (req_op == 3'd2);
    abs1 = (s_div && req_src1[31]) ?
           (~req_src1 + 32'd1) : req_src1;
    abs2 = (s_div && req_src2[31]) ?
           (~req_src2 + 32'd1) : req_src2;
`ifdef DIV_ZERO_FAST_EN
    fast_zero = is_div && (req_src2 == 32'd0);
    zero_lo = (s_div && req_src1[31]) ?
              32'd1 : 32'hFFFF_FFFF;
`endif
  end

  // Direct IDLE->RESP commits use live operands, MUL commits latched ones
  always_comb begin
    m_op = (state_q == S_IDLE) ? req_op   : op_q;
    m_a  = (state_q == S_IDLE) ? req_src1 : src1_q;
    m_b  = (state_q == S_IDLE) ? req_src2 : src2_q;
    sprod = $signed({{32{m_a[31]}}, m_a}) *
            $signed({{32{m_b[31]}}, m_b});
    uprod = {32'd0, m_a} * {32'd0, m_b};
    m_wr_hi = 1'b0;
    m_wr_lo = 1'b0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    case (m_op)
      3'd0: begin
        m_wr_hi = 1'b1;
        m_wr_lo = 1'b1;
        m_hi    = sprod[63:32];
        m_lo    = sprod[31:0];
      end
      3'd1: begin
        m_wr_hi = 1'b1;
        m_wr_lo = 1'b1;
        m_hi    = uprod[63:32];
        m_lo    = uprod[31:0];
      end
      3'd4: begin
        m_wr_hi = 1'b1;
        m_hi    = m_a;
      end
      3'd5: begin
        m_wr_lo = 1'b1;
        m_lo    = m_a;
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, den_q};
    if (diff[32]) begin
      step_rem = shifted[31:0];
      step_quo = {quo_q[30:0], 1'b0};
    end else begin
      step_rem = diff[31:0];
      step_quo = {quo_q[30:0], 1'b1};
    end
    fix_quo = qneg_q ? (~step_quo + 32'd1) : step_quo;
    fix_rem = rneg_q ? (~step_rem + 32'd1) : step_rem;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= 5'd0;
      op_q         <= 3'd0;
      src1_q       <= 32'd0;
      src2_q       <= 32'd0;
      rem_q        <= 32'd0;
      quo_q        <= 32'd0;
      den_q        <= 32'd0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
            busy_q <= 1'b1;
            if (is_div) begin
`ifdef DIV_ZERO_FAST_EN
              if (fast_zero) begin
                state_q      <= S_RESP;
                resp_valid_q <= 1'b1;
                hi_q         <= req_src1;
                lo_q         <= zero_lo;
              end else begin
`else
              begin
`endif
                state_q <= S_DIV;
                cnt_q   <= 5'd0;
                rem_q   <= 32'd0;
                quo_q   <= abs1;
                den_q   <= abs2;
                qneg_q  <= s_div &&
                           (req_src1[31] ^ req_src2[31]);
                rneg_q  <= s_div && req_src1[31];
              end
            end else if (MUL_DIRECT) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              if (m_wr_hi) hi_q <= m_hi;
              if (m_wr_lo) lo_q <= m_lo;
            end else begin
              state_q <= S_MUL;
              cnt_q   <= MUL_CNT0;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == 5'd0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            if (m_wr_hi) hi_q <= m_hi;
            if (m_wr_lo) lo_q <= m_lo;
          end else begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_DIV: begin
          if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            rem_q <= step_rem;
            quo_q <= step_quo;
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              hi_q         <= fix_rem;
              lo_q         <= fix_quo;
            end
          end
        end
        S_RESP: begin
          if (flush || resp_ready) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_hilo_ctrl.sv
// Random + directed bench for md_hilo_ctrl against a cycle-level
// behavioural model of HI/LO contents and handshake timing.
module tb_md_hilo_ctrl;

  localparam int ML = 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic        flush;
  logic        busy;
  logic [31:0] hi_rdata, lo_rdata;

  int checks = 0;
  int failures = 0;

  md_hilo_ctrl #(.MULT_LAT(ML)) dut (
    .clk(clk),
    .resetn(resetn),
    .req_valid(req_valid),
    .req_op(req_op),
    .req_src1(req_src1),
    .req_src2(req_src2),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .flush(flush),
    .busy(busy),
    .hi_rdata(hi_rdata),
    .lo_rdata(lo_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Architectural result of one operation
  task automatic mres(input logic [2:0] op,
                      input logic [31:0] a, b,
                      output logic wh, wl,
                      output logic [31:0] h, l);
    longint sa64, sb64, p;
    logic [63:0] u;
    int sa, sb;
    wh = 1'b0; wl = 1'b0; h = 32'd0; l = 32'd0;
    case (op)
      3'd0: begin
        sa64 = $signed(a); sb64 = $signed(b);
        p = sa64 * sb64;
        wh = 1; wl = 1; h = p[63:32]; l = p[31:0];
      end
      3'd1: begin
        u = {32'd0, a} * {32'd0, b};
        wh = 1; wl = 1; h = u[63:32]; l = u[31:0];
      end
      3'd2: begin
        wh = 1; wl = 1;
        if (b == 0) begin
          h = a; l = a[31] ? 32'd1 : 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 0; l = 32'h8000_0000;
        end else begin
          sa = a; sb = b;
          l = 32'(sa / sb); h = 32'(sa % sb);
        end
      end
      3'd3: begin
        wh = 1; wl = 1;
        if (b == 0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin l = a / b; h = a % b; end
      end
      3'd4: begin wh = 1; h = a; end
      3'd5: begin wl = 1; l = a; end
      default: ;
    endcase
  endtask

  // Model: idle / pending (due edge) / responding
  logic        m_busy, m_rv;
  logic [31:0] m_hi, m_lo;
  logic        p_wh, p_wl;
  logic [31:0] p_h, p_l;
  int          cyc = 0;
  int          due = 0;

  initial begin
    int lat;
    m_busy = 0; m_rv = 0; m_hi = 0; m_lo = 0;
    p_wh = 0; p_wl = 0; p_h = 0; p_l = 0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_busy = 0; m_rv = 0; m_hi = 0; m_lo = 0;
      end else if (!m_busy) begin
        if (req_valid && !flush) begin
          mres(req_op, req_src1, req_src2, p_wh, p_wl, p_h, p_l);
          if (req_op == 3'd2 || req_op == 3'd3) begin
            lat = 33;
`ifdef DIV_ZERO_FAST_EN
            if (req_src2 == 0) lat = 1;
`endif
          end else begin
            lat = ML;
          end
          m_busy = 1;
          if (lat == 1) begin
            if (p_wh) m_hi = p_h;
            if (p_wl) m_lo = p_l;
            m_rv = 1;
          end else begin
            due = cyc + lat - 1;
          end
        end
      end else if (!m_rv) begin
        if (flush) begin
          m_busy = 0;
        end else if (cyc == due) begin
          if (p_wh) m_hi = p_h;
          if (p_wl) m_lo = p_l;
          m_rv = 1;
        end
      end else if (flush || resp_ready) begin
        m_busy = 0; m_rv = 0;
      end
      cyc++;
      #1;
      chk("hi", hi_rdata, m_hi);
      chk("lo", lo_rdata, m_lo);
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_rv});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("req_ready", {31'd0, req_ready}, {31'd0, !m_busy && !flush});
    end
  end

  // Caller is at a negedge; drive for one cycle, then scramble req_*
  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a, b,
                       input int hold);
    req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
    resp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 0;
    req_op = 3'($urandom);
    req_src1 = $urandom;
    req_src2 = $urandom;
  endtask

  task automatic finish_op(input int hold, output int n);
    n = 0;
    while (!resp_valid && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (n >= 80) begin
      checks++; failures++;
      $display("FAIL resp_timeout got=none exp=resp_valid t=%0t", $time);
    end
    repeat (hold) @(negedge clk);
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;
  int div_lat;

  initial begin
`ifdef DIV_ZERO_FAST_EN
    div_lat = 0;
`else
    div_lat = 32;
`endif
    resetn = 0; req_valid = 0; req_op = 0;
    req_src1 = 0; req_src2 = 0; resp_ready = 0; flush = 0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi_rdata, 32'd0);
    chk("rst_lo", lo_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rv", {31'd0, resp_valid}, 32'd0);
    resetn = 1;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);

    issue(3'd3, 32'd100, 32'd7, 0);
    finish_op(0, n);
    chk("divu_lat", n, 32'd32);
    chk("divu_lo", lo_rdata, 32'd14);
    chk("divu_hi", hi_rdata, 32'd2);

    @(negedge clk);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    finish_op(0, n);
    chk("div_neg_lo", lo_rdata, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_rdata, 32'hFFFF_FFFF);
    @(negedge clk);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    finish_op(0, n);
    chk("div_ovf_lo", lo_rdata, 32'h8000_0000);
    chk("div_ovf_hi", hi_rdata, 32'd0);

    @(negedge clk);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    finish_op(0, n);
    chk("mult_lat", n, 32'(ML - 1));
    chk("mult_hi", hi_rdata, 32'hFFFF_FFFF);
    chk("mult_lo", lo_rdata, 32'hFFFF_FFFA);
    @(negedge clk);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, 0);
    finish_op(0, n);
    chk("multu_hi", hi_rdata, 32'd2);
    chk("multu_lo", lo_rdata, 32'hFFFF_FFFA);

    @(negedge clk);
    issue(3'd4, 32'h1234_5678, 32'd0, 0);
    finish_op(0, n);
    @(negedge clk);
    issue(3'd5, 32'h1234_5678, 32'd0, 0);
    finish_op(0, n);
    @(negedge clk);
    issue(3'd3, 32'd1000, 32'd3, 0);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_hi", hi_rdata, 32'h1234_5678);
    chk("flush_lo", lo_rdata, 32'h1234_5678);
    issue(3'd5, 32'hA5A5_A5A5, 32'd0, 0);
    finish_op(0, n);
    chk("mtlo_lo", lo_rdata, 32'hA5A5_A5A5);
    chk("mtlo_hi", hi_rdata, 32'h1234_5678);

    @(negedge clk);
    issue(3'd3, 32'd77, 32'd10, 5);
    finish_op(5, n);
    chk("hold_lo", lo_rdata, 32'd7);
    chk("hold_hi", hi_rdata, 32'd7);

    @(negedge clk);
    issue(3'd3, 32'd5, 32'd0, 0);
    finish_op(0, n);
    chk("divz_lat", n, 32'(div_lat));
    chk("divz_lo", lo_rdata, 32'hFFFF_FFFF);
    chk("divz_hi", hi_rdata, 32'd5);
    @(negedge clk);
    issue(3'd2, 32'hFFFF_FFFB, 32'd0, 0);
    finish_op(0, n);
    chk("sdivz_lo", lo_rdata, 32'd1);
    chk("sdivz_hi", hi_rdata, 32'hFFFF_FFFB);

    @(negedge clk);
    req_valid = 1; flush = 1; req_op = 3'd4;
    req_src1 = 32'hDEAD_BEEF;
    @(negedge clk);
    req_valid = 0; flush = 0;
    chk("idle_flush_busy", {31'd0, busy}, 32'd0);
    chk("idle_flush_hi", hi_rdata, 32'hFFFF_FFFB);

    @(negedge clk);
    issue(3'd2, 32'd1234, 32'd5, 0);
    repeat (5) @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("arst_hi", hi_rdata, 32'd0);
    chk("arst_lo", lo_rdata, 32'd0);
    chk("arst_rv", {31'd0, resp_valid}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    resetn = 1;

    for (int i = 0; i < 60; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      int hold;
      op = 3'($urandom_range(0, 7));
      a = rnd32();
      b = rnd32();
      hold = $urandom_range(0, 3);
      @(negedge clk);
      if ((op == 3'd2 || op == 3'd3) && $urandom_range(0, 3) == 0) begin
        issue(op, a, b, 1);
        repeat ($urandom_range(1, 30)) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
      end else begin
        issue(op, a, b, hold);
        finish_op(hold, n);
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
